spi_slave_io: RTL and testbench
===============================

Name: spi_slave_io

Overview:
- CPU-bus peripheral that makes the board an SPI target (mode 0, MSB first), so an external host can exchange bytes with firmware.
- It is the counterpart of the SD-card SPI master port: the external host drives SCK and SS, and this block responds.
- Sits on the 6801 system bus in the DS5 window at $E6B0–$E6B7, beside simpleio and uartio, and contributes to the CPU IRQ OR.
- Single clock: sys_clk.

Parameters:
- FILL_RESET, 8'hFF, reset value of the FILL register (byte sent when no TX byte is queued).

Ports:
- clk  in  1  system clock (sys_clk); all logic on posedge.
- rst  in  1  reset, asynchronous, active-low.
- AD  in  3  register address.
- DI  in  8  write data from CPU.
- DO  out  8  read data to CPU; combinational from AD.
- rw  in  1  1 = read, 0 = write.
- cs  in  1  chip select, already qualified with vma.
- irq  out  1  level interrupt request.
- ss_n  in  1  external slave select, active-low, asynchronous to clk.
- sck  in  1  external SPI clock, asynchronous to clk.
- mosi  in  1  external data in.
- miso  out  1  external data out.
- miso_oe  out  1  1 while selected; used for the top-level tristate.

Behaviour:
- Registers (AD):
  - 0 DATA: read returns RXD; write loads TXH.
  - 1 STATUS: bit0 RXF, bit1 TXE, bit2 OVR, bit3 SEL (synchronised ss active), bit7 irq; other bits 0. Write with DI[2]=1 clears OVR.
  - 2 CTRL: bit0 EN, bit1 RXIE, bit2 TXIE; read back, other bits 0.
  - 3 FILL: read/write.
  - 4–7: read 8'h00, writes ignored.
- Bus access:
  - Writes take effect on the posedge where cs=1 and rw=0.
  - A DATA read clears RXF on the posedge where cs=1, rw=1, AD=0.
- Reset values:
  - RXD=0, TXH=0, FILL=FILL_RESET, CTRL=0.
  - RXF=0, TXE=1, OVR=0, bitcnt=0, shift registers 0.
  - miso=1, miso_oe=0, irq=0.
- Input synchronisers:
  - sck, ss_n and mosi each pass through a 2-flop synchroniser, then one history flop.
  - Edges are detected on the synchronised values.
  - Supported SCK frequency is at most clk/8; faster SCK is unsupported.
- When EN=0: the SPI engine is held idle (bitcnt=0, miso_oe=0, miso=1); the CPU registers stay accessible.
- Engine (EN=1):
  - SS falling edge:
    - bitcnt=0, miso_oe=1.
    - If TXE=0: TSR<=TXH and TXE<=1; otherwise TSR<=FILL.
    - miso = TSR[7] from the next clk.
  - SCK rising edge while selected:
    - RSR <= {RSR[6:0], mosi_sync}; bitcnt++.
    - On the 8th rising edge (bitcnt 7→0 wrap):
      - If RXF=0: RXD <= completed byte, RXF<=1.
      - If RXF=1: the byte is discarded, RXD is unchanged, OVR<=1.
  - SCK falling edge while selected:
    - If bitcnt=0 (byte boundary), reload TSR from TXH or FILL, same rule as SS falling.
    - Otherwise TSR <= TSR<<1.
    - miso = TSR[7].
  - SS rising edge:
    - miso_oe<=0, miso=1, bitcnt=0.
    - A partial byte is discarded: no RXF, no OVR.
    - A TXH byte already moved into TSR is consumed and not re-sent.
- Simultaneous events:
  - CPU DATA read in the same cycle a byte completes with RXF=1: the clear wins first. The new byte is stored, RXF stays 1, and OVR is not set.
  - CPU DATA write in the same cycle TSR reloads: the reload uses the pre-write TXE/TXH. The write then lands in TXH and TXE<=0.
  - CPU DATA write while TXE=0: TXH is overwritten silently.
- irq = (RXF & RXIE) | (TXE & TXIE & EN), registered, 1-cycle latency from the flag change.
- Asserting rst mid-transfer returns everything to reset values immediately, including miso=1 and miso_oe=0.

Test Plan:
1. Reset, write CTRL=8'h01, host sends 8'hA5 with SCK=clk/8 -> RXF=1, DATA reads 8'hA5, RXF=0 after the read, OVR=0.
2. CPU writes DATA=8'h3C before SS falls; host clocks 8 bits -> host receives 8'h3C on miso, TXE=1 from the cycle after SS synchronisation.
3. No TX byte queued, FILL=8'h81; host sends two bytes -> host sees 8'h81, 8'h81.
4. Host sends 8'h11 then 8'h22 without a CPU read -> RXD=8'h11, OVR=1; STATUS write 8'h04 clears OVR.
5. CTRL=8'h07, TXE=1 -> irq=1. Write DATA -> irq=0 until the byte loads. Byte received -> irq=1; DATA read clears it when TXE=0.
6. Host drops SS after 5 bits -> RXF=0, miso=1, miso_oe=0. The next full byte 8'h5A is received correctly. Assert rst mid-byte -> all registers at reset values.

Source files
------------

// File: rtl/spi_slave_io.sv
// SPI mode-0 target on the 6801 bus: the external host drives SCK/SS, and the CPU exchanges
// bytes through DATA/STATUS/CTRL/FILL. All SPI inputs are resynchronised into clk.
module spi_slave_io #(
    parameter logic [7:0] FILL_RESET = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    output logic       irq,
    input  logic       ss_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_FILL   = 3'd3;

    // Synchroniser chains; ss_n and sck idle high/low so reset does not fake an edge.
    logic       sck_s1_q, sck_s2_q, sck_h_q;
    logic       ss_s1_q, ss_s2_q, ss_h_q;
    logic       mosi_s1_q, mosi_s2_q;

    logic [7:0] rxd_q, rxd_d;
    logic [7:0] txh_q, txh_d;
    logic [7:0] fill_q, fill_d;
    logic [2:0] ctrl_q, ctrl_d;
    logic       rxf_q, rxf_d;
    logic       txe_q, txe_d;
    logic       ovr_q, ovr_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] tsr_q, tsr_d;
    logic [7:0] rsr_q, rsr_d;
    logic       oe_q, oe_d;
    logic       irq_q, irq_d;

    logic       en;
    logic       wr_data, wr_status, wr_ctrl, wr_fill, rd_data;
    logic       ss_fall, ss_rise, sck_rise, sck_fall;
    logic       tsr_load, byte_done;
    logic [7:0] rx_byte;

    assign en        = ctrl_q[0];
    assign wr_data   = cs && !rw && (AD == A_DATA);
    assign wr_status = cs && !rw && (AD == A_STATUS);
    assign wr_ctrl   = cs && !rw && (AD == A_CTRL);
    assign wr_fill   = cs && !rw && (AD == A_FILL);
    assign rd_data   = cs &&  rw && (AD == A_DATA);

    assign ss_fall   =  ss_h_q  && !ss_s2_q;
    assign ss_rise   = !ss_h_q  &&  ss_s2_q;
    assign sck_rise  = !sck_h_q &&  sck_s2_q;
    assign sck_fall  =  sck_h_q && !sck_s2_q;
    assign rx_byte   = {rsr_q[6:0], mosi_s2_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_h_q   <= 1'b0;
            ss_s1_q   <= 1'b1;
            ss_s2_q   <= 1'b1;
            ss_h_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= sck;
            sck_s2_q  <= sck_s1_q;
            sck_h_q   <= sck_s2_q;
            ss_s1_q   <= ss_n;
            ss_s2_q   <= ss_s1_q;
            ss_h_q    <= ss_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    // Shift engine: selection, bit counting and TSR reload decisions.
    always_comb begin
        bitcnt_d  = bitcnt_q;
        oe_d      = oe_q;
        rsr_d     = rsr_q;
        tsr_load  = 1'b0;
        byte_done = 1'b0;
        tsr_d     = tsr_q;
        if (!en) begin
            bitcnt_d = 3'd0;
            oe_d     = 1'b0;
        end else if (ss_fall) begin
            bitcnt_d = 3'd0;
            oe_d     = 1'b1;
            tsr_load = 1'b1;
        end else if (ss_rise) begin
            bitcnt_d = 3'd0;
            oe_d     = 1'b0;
        end else if (oe_q) begin
            if (sck_rise) begin
                rsr_d     = rx_byte;
                bitcnt_d  = bitcnt_q + 3'd1;
                byte_done = (bitcnt_q == 3'd7);
            end else if (sck_fall) begin
                if (bitcnt_q == 3'd0) begin
                    tsr_load = 1'b1;
                end else begin
                    tsr_d = {tsr_q[6:0], 1'b0};
                end
            end
        end
        if (tsr_load) begin
            tsr_d = txe_q ? fill_q : txh_q;
        end
    end

    // Flag and CPU register updates; a reload sees pre-write TXE/TXH, then the write lands.
    always_comb begin
        rxd_d  = rxd_q;
        rxf_d  = rxf_q;
        ovr_d  = ovr_q;
        txh_d  = txh_q;
        txe_d  = txe_q;
        fill_d = fill_q;
        ctrl_d = ctrl_q;
        if (rd_data) begin
            rxf_d = 1'b0;
        end
        if (wr_status && DI[2]) begin
            ovr_d = 1'b0;
        end
        if (byte_done) begin
            if (rxf_q && !rd_data) begin
                ovr_d = 1'b1;
            end else begin
                rxd_d = rx_byte;
                rxf_d = 1'b1;
            end
        end
        if (tsr_load && !txe_q) begin
            txe_d = 1'b1;
        end
        if (wr_data) begin
            txh_d = DI;
            txe_d = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_d = DI[2:0];
        end
        if (wr_fill) begin
            fill_d = DI;
        end
        irq_d = (rxf_q && ctrl_q[1]) || (txe_q && ctrl_q[2] && en);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_q    <= 8'h00;
            txh_q    <= 8'h00;
            fill_q   <= FILL_RESET;
            ctrl_q   <= 3'b000;
            rxf_q    <= 1'b0;
            txe_q    <= 1'b1;
            ovr_q    <= 1'b0;
            bitcnt_q <= 3'd0;
            tsr_q    <= 8'h00;
            rsr_q    <= 8'h00;
            oe_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            rxd_q    <= rxd_d;
            txh_q    <= txh_d;
            fill_q   <= fill_d;
            ctrl_q   <= ctrl_d;
            rxf_q    <= rxf_d;
            txe_q    <= txe_d;
            ovr_q    <= ovr_d;
            bitcnt_q <= bitcnt_d;
            tsr_q    <= tsr_d;
            rsr_q    <= rsr_d;
            oe_q     <= oe_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        case (AD)
            A_DATA:   DO = rxd_q;
            A_STATUS: DO = {irq_q, 3'b000, !ss_s2_q, ovr_q, txe_q, rxf_q};
            A_CTRL:   DO = {5'b00000, ctrl_q};
            A_FILL:   DO = fill_q;
            default:  DO = 8'h00;
        endcase
    end

    assign miso    = oe_q ? tsr_q[7] : 1'b1;
    assign miso_oe = oe_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_spi_slave_io.sv
// Randomised bench for spi_slave_io: a byte-level model predicts what the host sees on miso
// (scoreboard queue checked by a monitor) and what the CPU reads back from the registers.
module tb_spi_slave_io;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] AD = 3'd0;
    logic [7:0] DI = 8'h00;
    logic [7:0] DO;
    logic       rw = 1'b1;
    logic       cs = 1'b0;
    logic       irq;
    logic       ss_n = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;

    spi_slave_io #(.FILL_RESET(8'hFF)) dut (
        .clk(clk), .rst(rst_n), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
        .ss_n(ss_n), .sck(sck), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Byte-level model of the peripheral
    logic [7:0] m_rxd, m_txh, m_fill;
    logic [2:0] m_ctrl;
    logic       m_rxf, m_txe, m_ovr;
    logic [7:0] exp_q[$];
    logic [7:0] hb[0:3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rxd = 8'h00; m_txh = 8'h00; m_fill = 8'hFF; m_ctrl = 3'b000;
        m_rxf = 1'b0;  m_txe = 1'b1;  m_ovr = 1'b0;
    endtask

    function automatic logic exp_irq();
        return (m_rxf & m_ctrl[1]) | (m_txe & m_ctrl[2] & m_ctrl[0]);
    endfunction

    function automatic logic [7:0] exp_status();
        return {exp_irq(), 3'b000, 1'b0, m_ovr, m_txe, m_rxf};
    endfunction

    // Next byte the target will present: queued TX byte if any, else FILL.
    task automatic load_slot(output logic [7:0] b);
        if (!m_txe) begin
            b = m_txh;
            m_txe = 1'b1;
        end else begin
            b = m_fill;
        end
    endtask

    task automatic rx_model(input logic [7:0] b);
        if (m_rxf) m_ovr = 1'b1;
        else begin
            m_rxd = b;
            m_rxf = 1'b1;
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b0; AD = a; DI = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
        case (a)
            3'd0: begin m_txh = d; m_txe = 1'b0; end
            3'd1: if (d[2]) m_ovr = 1'b0;
            3'd2: m_ctrl = d[2:0];
            3'd3: m_fill = d;
            default: ;
        endcase
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; AD = a;
        #1 d = DO;
        @(negedge clk);
        cs = 1'b0;
        if (a == 3'd0) m_rxf = 1'b0;
    endtask

    task automatic check_status(input string name);
        logic [7:0] v;
        cpu_rd(3'd1, v);
        chk(name, v, exp_status());
    endtask

    task automatic check_data(input string name);
        logic [7:0] v;
        logic [7:0] e;
        e = m_rxd;
        cpu_rd(3'd0, v);
        chk(name, v, e);
    endtask

    task automatic check_irq_pin(input string name);
        @(negedge clk);
        chk(name, irq, exp_irq());
    endtask

    // Host side: SCK = clk/8, data changes on falling edge, sampled on rising edge.
    task automatic host_xfer(input int nbits);
        logic [7:0] slot;
        @(negedge clk);
        ss_n = 1'b0;
        mosi = hb[0][7];
        load_slot(slot);
        if (nbits >= 8) exp_q.push_back(slot);
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
            if ((i % 8) == 7) begin
                rx_model(hb[i / 8]);
                load_slot(slot);
                if (nbits - (i + 1) >= 8) exp_q.push_back(slot);
            end
            if (i + 1 < nbits) mosi = hb[(i + 1) / 8][7 - ((i + 1) % 8)];
            repeat (4) @(negedge clk);
        end
        ss_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Monitor: assemble what the host sees on miso and score each full byte.
    logic [7:0] mon_byte = 8'h00;
    int         mon_cnt = 0;
    always @(posedge sck or posedge ss_n) begin
        if (ss_n) begin
            mon_cnt = 0;
        end else begin
            mon_byte = {mon_byte[6:0], miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL miso_unexpected: got %0h expected none", mon_byte);
                end else begin
                    chk("miso_byte", mon_byte, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 1'b1);
        chk("rst_oe", miso_oe, 1'b0);
        chk("rst_irq", irq, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_data("rst_data");
        check_status("rst_status");
        cpu_rd(3'd2, v); chk("rst_ctrl", v, 8'h00);
        cpu_rd(3'd3, v); chk("rst_fill", v, 8'hFF);

        // Unused addresses
        cpu_wr(3'd5, 8'hFF);
        cpu_rd(3'd5, v); chk("addr5", v, 8'h00);

        // Receive A5, host sees FILL
        cpu_wr(3'd2, 8'h01);
        cpu_rd(3'd2, v); chk("ctrl_rb", v, 8'h01);
        hb[0] = 8'hA5;
        host_xfer(8);
        check_status("t1_status_full");
        check_data("t1_data");
        check_status("t1_status_empty");

        // Queued TX byte
        cpu_wr(3'd0, 8'h3C);
        check_status("t2_txe0");
        hb[0] = 8'h96;
        host_xfer(8);
        check_status("t2_status");
        check_data("t2_data");

        // FILL bytes and overrun
        cpu_wr(3'd3, 8'h81);
        hb[0] = 8'h11; hb[1] = 8'h22;
        host_xfer(16);
        check_status("t4_ovr");
        check_data("t4_data");
        cpu_wr(3'd1, 8'h04);
        check_status("t4_ovr_clr");

        // Interrupts
        cpu_wr(3'd2, 8'h07);
        check_irq_pin("t5_irq_txe");
        cpu_wr(3'd0, 8'h5E);
        check_irq_pin("t5_irq_txfull");
        hb[0] = 8'hC3;
        host_xfer(8);
        check_irq_pin("t5_irq_rx");
        cpu_wr(3'd0, 8'h77);
        check_data("t5_data");
        check_irq_pin("t5_irq_clr");
        check_status("t5_status");

        // Aborted byte, then a clean one
        hb[0] = 8'hF0;
        host_xfer(5);
        chk("t6_miso_idle", miso, 1'b1);
        chk("t6_oe_idle", miso_oe, 1'b0);
        check_status("t6_partial");
        hb[0] = 8'h5A;
        host_xfer(8);
        check_data("t6_data");

        // Randomised traffic
        for (int it = 0; it < 25; it++) begin
            int nb;
            if ($urandom_range(0, 2) == 0) cpu_wr(3'd3, 8'($urandom));
            if ($urandom_range(0, 1) == 0) cpu_wr(3'd0, 8'($urandom));
            if ($urandom_range(0, 3) == 0) cpu_wr(3'd2, {5'b0, 2'($urandom), 1'b1});
            nb = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) hb[k] = 8'($urandom);
            host_xfer(nb * 8);
            check_status("rnd_status");
            chk("rnd_irq", irq, exp_irq());
            if ($urandom_range(0, 2) != 0) check_data("rnd_data");
            if ($urandom_range(0, 1) == 0) cpu_wr(3'd1, 8'h04);
        end

        // Reset in the middle of a byte
        cpu_wr(3'd2, 8'h07);
        cpu_wr(3'd0, 8'hAB);
        hb[0] = 8'h3F;
        fork
            host_xfer(5);
            begin
                repeat (22) @(negedge clk);
                rst_n = 1'b0;
                #1;
                chk("mid_rst_miso", miso, 1'b1);
                chk("mid_rst_oe", miso_oe, 1'b0);
                chk("mid_rst_irq", irq, 1'b0);
            end
        join
        model_reset();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_data("mid_rst_data");
        check_status("mid_rst_status");
        cpu_rd(3'd2, v); chk("mid_rst_ctrl", v, 8'h00);
        cpu_rd(3'd3, v); chk("mid_rst_fill", v, 8'hFF);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
